// File: rtl/jtdd_pkg.sv
// Shared constants and FSM state encoding for the ROM arbiter.
package jtdd_pkg;

    localparam int SDRAM_AW = 22;
    localparam int DW       = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/jtdd_rr_pick.sv
// Grant picker: round-robin after the last grant, or fixed priority (lowest index)
// when JTDD_ROM_ARB_FIXPRIO_EN is defined.
module jtdd_rr_pick #(
    parameter int CH = 4,
    parameter int IW = 2
) (
    input  logic [CH-1:0] pending,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant,
    output logic          any
);

`ifdef JTDD_ROM_ARB_FIXPRIO_EN
    logic unused_last;
    assign unused_last = ^last;

    // Scan downwards so the lowest pending index is the final assignment
    always_comb begin
        grant = '0;
        any   = |pending;
        for (int i = CH - 1; i >= 0; i--) begin
            if (pending[i]) grant = IW'(i);
        end
    end
`else
    // Search starts one past the last grant and wraps at CH-1
    always_comb begin
        int  idx;
        logic found;
        grant = '0;
        any   = |pending;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= CH; k++) begin
            idx = (int'(last) + k) % CH;
            if (!found && pending[idx]) begin
                grant = IW'(idx);
                found = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/jtdd_rom_arb.sv
// Multi-channel ROM fetch arbiter with a one-word cache per channel in front of SDRAM.
// Optional JTDD_ROM_ARB_FIXPRIO_EN selects fixed-priority grants instead of round-robin.
module jtdd_rom_arb
    import jtdd_pkg::*;
#(
    parameter int                  CH      = 4,
    parameter int                  AW      = 17,
    parameter logic [CH*22-1:0]    OFFSETS = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                downloading,
    input  logic [CH-1:0]       cs,
    input  logic [CH*AW-1:0]    addr,
    output logic [CH*DW-1:0]    dout,
    output logic [CH-1:0]       ok,
    output logic                sdram_req,
    output logic [SDRAM_AW-1:0] sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [DW-1:0]       data_read,
    output logic                refresh_en
);

    localparam int IW = (CH > 1) ? $clog2(CH) : 1;

    arb_state_t    state, next_state;
    logic [IW-1:0] grant_q, last_q, pick;
    logic          pick_any;
    logic [AW-1:0] addr_q, pick_addr;
    logic [AW-1:0] tag_q  [CH];
    logic [DW-1:0] data_q [CH];
    logic [CH-1:0] valid_q, hit, pending;
    logic          discard_q;

    always_comb begin
        hit  = '0;
        dout = '0;
        for (int i = 0; i < CH; i++) begin
            hit[i]                = cs[i] && valid_q[i] && (tag_q[i] == addr[i*AW +: AW]);
            dout[i*DW +: DW]      = data_q[i];
        end
        pending   = cs & ~hit;
        ok        = hit;
        pick_addr = addr[int'(pick)*AW +: AW];
    end

    jtdd_rr_pick #(
        .CH (CH),
        .IW (IW)
    ) u_pick (
        .pending (pending),
        .last    (last_q),
        .grant   (pick),
        .any     (pick_any)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (pick_any && !downloading) next_state = ST_REQ;
            ST_REQ:  if (sdram_ack)                next_state = ST_WAIT;
            ST_WAIT: if (data_rdy)                 next_state = ST_IDLE;
            default:                               next_state = ST_IDLE;
        endcase
        sdram_req  = (state == ST_REQ);
        refresh_en = (state == ST_IDLE) && !pick_any && !rst;
    end

    // A transaction that overlaps a download still runs to completion, but its data is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant_q    <= '0;
            last_q     <= IW'(CH - 1);
            addr_q     <= '0;
            sdram_addr <= '0;
            discard_q  <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && next_state == ST_REQ) begin
                grant_q    <= pick;
                last_q     <= pick;
                addr_q     <= pick_addr;
                sdram_addr <= OFFSETS[int'(pick)*SDRAM_AW +: SDRAM_AW] + SDRAM_AW'(pick_addr);
                discard_q  <= 1'b0;
            end else if (downloading && state != ST_IDLE) begin
                discard_q  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < CH; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (downloading) begin
            valid_q <= '0;
        end else if (state == ST_WAIT && data_rdy && !discard_q) begin
            tag_q[grant_q]   <= addr_q;
            data_q[grant_q]  <= data_read;
            valid_q[grant_q] <= 1'b1;
        end
    end

endmodule

// File: doc/jtdd_rom_arb.md
JTDD_ROM_ARB -- requirements
Module: jtdd_rom_arb

Interface
REQ-001 SHALL have parameter CH, default 4, meaning number of ROM client channels (1..8).
REQ-002 SHALL have parameter AW, default 17, meaning per-channel word address width.
REQ-003 SHALL have parameter OFFSETS, default 0, meaning a CH x 22-bit flat vector of SDRAM base offsets, channel 0 in the LSBs.
REQ-004 SHALL have port clk  in  1  the single system clock; every register is clocked on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port downloading  in  1  ROM load in progress; while high, all client service is suspended.
REQ-007 SHALL have port cs  in  CH  per-channel fetch request.
REQ-008 SHALL have port addr  in  CH*AW  per-channel word address, flat, channel 0 in the LSBs.
REQ-009 SHALL have port dout  out  CH*32  per-channel latched SDRAM word.
REQ-010 SHALL have port ok  out  CH  per-channel flag meaning dout is valid for the current addr.
REQ-011 SHALL have ports sdram_req out 1, sdram_addr out 22, sdram_ack in 1, data_rdy in 1, data_read in 32, refresh_en out 1.

Function
REQ-012 SHALL hold a per-channel cache of one tag (AW bits), one valid bit and one 32-bit data word.
REQ-013 SHALL drive ok[i] high combinationally when cs[i], valid[i] and tag[i]==addr[i] all hold, giving a zero-cycle hit.
REQ-014 SHALL mark channel i pending when cs[i] is high and the channel is not a hit.
REQ-015 SHALL run an FSM with states IDLE, REQ and WAIT.
REQ-016 SHALL move IDLE->REQ on the cycle any channel is pending, while downloading is low; on that edge it latches the granted channel index and its addr.
REQ-017 SHALL, in REQ, hold sdram_req=1 and sdram_addr = OFFSETS[grant] + latched addr, using a 22-bit add that wraps.
REQ-018 SHALL move REQ->WAIT on sdram_ack, dropping sdram_req in the same cycle.
REQ-019 SHALL, in WAIT, on data_rdy write data_read and the latched addr into the granted channel's cache, set its valid bit, and return to IDLE.
REQ-020 SHALL grant round-robin: search starts at the channel after the last grant, wrapping at CH-1.
REQ-021 SHALL still fill the cache from an in-flight fetch when the client's addr changed mid-fetch; ok stays low via the tag compare, and the new address is fetched on a later grant.
REQ-022 SHALL, on data_rdy for channel i in the same cycle as a new miss on channel j, complete i and grant j no earlier than the following cycle.
REQ-023 SHALL drive refresh_en high only in IDLE with no channel pending.
REQ-024 SHALL clear every valid bit on the cycle downloading rises, hold the FSM in IDLE while downloading is high, and allow an in-flight transaction to complete but discard its data.

Reset
REQ-025 SHALL, on rst high, asynchronously force: state=IDLE, sdram_req=0, sdram_addr=0, all valid=0, ok=0, dout=0, round-robin pointer=CH-1, refresh_en=0.
REQ-026 SHALL abandon any transaction that rst interrupts; sdram_ack and data_rdy arriving after release in IDLE SHALL be ignored.

Configuration
REQ-027 SHALL, with macro JTDD_ROM_ARB_FIXPRIO_EN defined, grant by fixed priority with the lowest index winning; without it, arbitration SHALL be round-robin per REQ-020.

Structure
REQ-028 SHALL take the FSM state encoding, the 22-bit SDRAM address width constant and the 32-bit data width constant from shared package jtdd_pkg.
REQ-029 SHALL implement the grant logic as sub-module jtdd_rr_pick (inputs: pending vector, last grant; outputs: grant index, any); the fixed-priority mode is selected inside it.

Verification
REQ-030 SHALL verify that CH=4, OFFSETS[1]=22'h8000, cs[1]=1, addr1=17'h10, ack at +2, rdy at +5 gives sdram_addr=22'h8010, ok[1] high the cycle after rdy, and dout1=data_read.
REQ-031 SHALL verify that repeating the same cs[1] and addr after a fill gives ok[1] high in the same cycle with no sdram_req.
REQ-032 SHALL verify that cs on channels 0, 2 and 3 simultaneously, with last grant 0, serves 2, 3, 0 in that order; with JTDD_ROM_ARB_FIXPRIO_EN defined the order is 0, 2, 3.
REQ-033 SHALL verify that changing addr0 from 5 to 6 during WAIT leaves ok[0] low after rdy and issues a second request for 6.
REQ-034 SHALL verify that raising downloading after a fill drops ok to 0 and gives sdram_req=0 for as long as downloading is high.
REQ-035 SHALL verify that asserting rst in WAIT gives sdram_req=0 immediately, and that a late data_rdy after release leaves ok and dout at 0.
